fetch_sequencer: RTL and testbench



---
 rtl/fetch_sequencer.sv | 117 +++++++++++
 tb/tb_fetch_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// In-order instruction fetch sequencer: issues fetches from pc_f, tags responses with their
// address, and presents them through a 2-entry buffer with redirect/exception flushing.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] EXC_VEC  = 32'h0000_4180,
   parameter logic [31:0] IM_LO    = 32'h0000_3000,
   parameter logic [31:0] IM_HI    = 32'h0000_6FFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        exc,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        im_req,
   output logic [31:0] im_addr,
   input  logic        im_gnt,
   input  logic        im_rvalid,
   input  logic [31:0] im_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        adel
);

   typedef enum logic {RUN = 1'b0, ERR = 1'b1} state_t;

   typedef struct packed {
      logic [31:0] word;
      logic [31:0] pc;
      logic        err;
   } entry_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [1:0]  out_q, out_d;
   logic [1:0]  disc_q, disc_d;
   logic [1:0]  occ_q, occ_d;
   entry_t      buf_q [2];
   entry_t      buf_d [2];
   logic [31:0] tag_q [2];
   logic [31:0] tag_d [2];

   logic flush, legal, fire, pop, push_rsp, push_err;
   logic buf_wr_idx, tag_wr_idx;

   always_comb begin
      flush       = exc | redirect;
      legal       = (pc_q[1:0] == 2'b00) && (pc_q >= IM_LO) && (pc_q <= IM_HI);
      // Outstanding plus buffered never exceeds 2, so every response always has a free slot.
      im_req      = !reset && (state_q == RUN) && !flush && legal &&
                    (({1'b0, out_q} + {1'b0, occ_q}) < 3'd2);
      fire        = im_req && im_gnt;
      instr_valid = !reset && (occ_q != 2'd0);
      pop         = instr_valid && instr_ready;
      push_rsp    = im_rvalid && !flush && (disc_q == 2'd0) && (state_q == RUN);
      push_err    = (state_q == RUN) && !flush && !legal && (out_q == 2'd0) && (occ_q != 2'd2);
      buf_wr_idx  = (occ_q == 2'd2) || ((occ_q == 2'd1) && !pop);
      tag_wr_idx  = out_q[0] && !im_rvalid;
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      disc_d  = disc_q;
      buf_d   = buf_q;
      tag_d   = tag_q;

      if (im_rvalid) tag_d[0] = tag_q[1];
      if (fire) tag_d[tag_wr_idx] = pc_q;
      out_d = out_q + {1'b0, fire} - {1'b0, im_rvalid};

      if (pop) buf_d[0] = buf_q[1];
      if (push_rsp) buf_d[buf_wr_idx] = '{word: im_rdata, pc: tag_q[0], err: 1'b0};
      if (push_err) buf_d[buf_wr_idx] = '{word: 32'h0, pc: pc_q, err: 1'b1};
      occ_d = occ_q - {1'b0, pop} + {1'b0, push_rsp | push_err};

      if (im_rvalid && (disc_q != 2'd0)) disc_d = disc_q - 2'd1;
      if (fire) pc_d = pc_q + 32'd4;
      if (push_err) state_d = ERR;

      // Responses still in flight belong to the abandoned path and must be swallowed.
      if (flush) begin
         pc_d    = exc ? EXC_VEC : redirect_pc;
         state_d = RUN;
         occ_d   = 2'd0;
         disc_d  = out_q - {1'b0, im_rvalid};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         out_q   <= 2'd0;
         disc_q  <= 2'd0;
         occ_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         out_q   <= out_d;
         disc_q  <= disc_d;
         occ_q   <= occ_d;
      end
   end

   always_ff @(posedge clk) begin
      buf_q <= buf_d;
      tag_q <= tag_d;
   end

   assign im_addr  = pc_q;
   assign instr    = reset ? 32'h0 : buf_q[0].word;
   assign instr_pc = reset ? 32'h0 : buf_q[0].pc;
   assign adel     = reset ? 1'b0  : buf_q[0].err;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a stream model predicts every entry the decode side
// consumes; a bench-side memory answers grants in order with randomized latency.
module tb_fetch_sequencer;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
   localparam logic [31:0] IM_LO    = 32'h0000_3000;
   localparam logic [31:0] IM_HI    = 32'h0000_6FFF;

   logic        clk;
   logic        reset       = 1'b1;
   logic        exc         = 1'b0;
   logic        redirect    = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        im_req;
   logic [31:0] im_addr;
   logic        im_gnt      = 1'b0;
   logic        im_rvalid   = 1'b0;
   logic [31:0] im_rdata    = 32'h0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        adel;

   int n_cmp   = 0;
   int n_fail  = 0;
   int n_gnt   = 0;
   int n_pop   = 0;
   int gnt_pct = 100;
   int rv_pct  = 100;

   typedef struct {
      logic [31:0] word;
      logic [31:0] pc;
      logic        err;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] pend_q[$];
   logic [31:0] pop_log[$];

   fetch_sequencer #(
      .RESET_PC(RESET_PC), .EXC_VEC(EXC_VEC), .IM_LO(IM_LO), .IM_HI(IM_HI)
   ) dut (
      .clk(clk), .reset(reset), .exc(exc), .redirect(redirect), .redirect_pc(redirect_pc),
      .im_req(im_req), .im_addr(im_addr), .im_gnt(im_gnt), .im_rvalid(im_rvalid),
      .im_rdata(im_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .instr_pc(instr_pc), .adel(adel)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   function automatic bit is_legal(input logic [31:0] a);
      return (a % 4 == 0) && (a >= IM_LO) && (a <= IM_HI);
   endfunction

   // Expected consumption stream from a fetch target: sequential words until the first
   // illegal address, which yields one address-error entry and then nothing.
   task automatic model_restart(input logic [31:0] target);
      logic [31:0] a;
      exp_t e;
      a = target;
      exp_q.delete();
      for (int i = 0; i < 64; i++) begin
         if (is_legal(a)) begin
            e.word = mem_word(a); e.pc = a; e.err = 1'b0;
            exp_q.push_back(e);
            a = a + 32'd4;
         end else begin
            e.word = 32'h0; e.pc = a; e.err = 1'b1;
            exp_q.push_back(e);
            break;
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %b, required %b", name, act, req);
      end
   endtask

   task automatic check_log(input string name, input int idx, input logic [31:0] req);
      if (pop_log.size() > idx) check(name, pop_log[idx], req);
      else begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s: no entry consumed, required pc %h", name, req);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [31:0] pick_target(input int k);
      case (k)
         0: return 32'h0000_3000;
         1: return 32'h0000_3100;
         2: return 32'h0000_4180;
         3: return 32'h0000_6FF0;
         4: return 32'h0000_6FFC;
         5: return 32'h0000_7000;
         6: return 32'h0000_2FFC;
         7: return 32'h0000_3002;
         8: return 32'h5555_5554;
         default: return 32'h0000_4001;
      endcase
   endfunction

   // Model bookkeeping just after each edge: reset outranks exc, exc outranks redirect.
   initial forever begin
      @(posedge clk);
      #1;
      if (reset) model_restart(RESET_PC);
      else if (exc) model_restart(EXC_VEC);
      else if (redirect) model_restart(redirect_pc);
   end

   // Instruction memory: in-order responses, never earlier than the cycle after the grant.
   initial forever begin
      @(negedge clk);
      #1;
      im_gnt = (int'($urandom_range(99)) < gnt_pct);
      if (pend_q.size() > 0 && int'($urandom_range(99)) < rv_pct) begin
         im_rvalid = 1'b1;
         im_rdata  = mem_word(pend_q[0]);
      end else begin
         im_rvalid = 1'b0;
         im_rdata  = $urandom;
      end
      #3;
      if (reset) pend_q.delete();
      else begin
         if (im_rvalid) void'(pend_q.pop_front());
         if (im_req && im_gnt) begin
            pend_q.push_back(im_addr);
            n_gnt++;
         end
      end
   end

   // Monitor: compares every consumed entry and the held head under backpressure.
   initial begin
      exp_t        e;
      logic        hold;
      logic [31:0] h_word, h_pc;
      logic        h_err;
      hold = 1'b0;
      forever begin
         @(negedge clk);
         #4;
         if (!reset) begin
            if (hold) begin
               check_bit("hold_valid", instr_valid, 1'b1);
               check("hold_pc", instr_pc, h_pc);
               check("hold_instr", instr, h_word);
               check_bit("hold_adel", adel, h_err);
            end
            if (instr_valid && instr_ready) begin
               n_pop++;
               pop_log.push_back(instr_pc);
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL unexpected_entry: got pc %h, required no entry", instr_pc);
               end else begin
                  e = exp_q.pop_front();
                  check("entry_pc", instr_pc, e.pc);
                  check("entry_instr", instr, e.word);
                  check_bit("entry_adel", adel, e.err);
               end
            end
         end
         hold   = !reset && instr_valid && !instr_ready && !exc && !redirect;
         h_word = instr;
         h_pc   = instr_pc;
         h_err  = adel;
      end
   end

   initial begin
      int          g0, r, since;
      logic [31:0] ae_tgt [2];
      ae_tgt[0] = 32'h0000_3002;
      ae_tgt[1] = 32'h0000_7000;

      cyc(3);
      #2;
      check_bit("rst_im_req", im_req, 1'b0);
      check_bit("rst_valid", instr_valid, 1'b0);
      check("rst_instr", instr, 32'h0);
      check("rst_instr_pc", instr_pc, 32'h0);
      check_bit("rst_adel", adel, 1'b0);
      check("rst_im_addr", im_addr, RESET_PC);

      // Streaming with single-cycle memory latency.
      cyc(1);
      reset = 1'b0; instr_ready = 1'b1; pop_log.delete();
      cyc(12);
      #2;
      check_log("stream_0", 0, 32'h3000);
      check_log("stream_1", 1, 32'h3004);
      check_log("stream_2", 2, 32'h3008);

      // Backpressure from a clean restart at 0x3000.
      cyc(1);
      instr_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h3000;
      cyc(1);
      redirect = 1'b0; g0 = n_gnt;
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         #2;
         if (instr_valid) check("bp_head_pc", instr_pc, 32'h3000);
      end
      check_bit("bp_grants_le2", (n_gnt - g0) <= 2, 1'b1);
      check_bit("bp_req_full", im_req, 1'b0);
      check_bit("bp_valid", instr_valid, 1'b1);
      cyc(1);
      instr_ready = 1'b1;
      cyc(6);

      // Redirect with two fetches in flight.
      gnt_pct = 0;
      cyc(4);
      redirect = 1'b1; redirect_pc = 32'h3000; rv_pct = 0; gnt_pct = 100;
      cyc(1);
      redirect = 1'b0;
      cyc(3);
      #2;
      check_bit("if_req_blocked", im_req, 1'b0);
      cyc(1);
      redirect = 1'b1; redirect_pc = 32'h3100;
      cyc(1);
      redirect = 1'b0; rv_pct = 100; pop_log.delete();
      cyc(8);
      check_log("if_first_pc", 0, 32'h3100);

      // exc + redirect in the same cycle as a response.
      gnt_pct = 0;
      cyc(4);
      redirect = 1'b1; redirect_pc = 32'h3000; rv_pct = 0; gnt_pct = 100;
      cyc(1);
      redirect = 1'b0;
      cyc(2);
      exc = 1'b1; redirect = 1'b1; redirect_pc = 32'h3200; rv_pct = 100;
      cyc(1);
      exc = 1'b0; redirect = 1'b0; pop_log.delete();
      #2;
      check("prio_im_addr", im_addr, EXC_VEC);
      cyc(8);
      check_log("prio_first_pc", 0, EXC_VEC);

      // Address errors: misaligned, then past the top of the legal range.
      for (int t = 0; t < 2; t++) begin
         gnt_pct = 0;
         cyc(4);
         gnt_pct = 100; instr_ready = 1'b0; redirect = 1'b1; redirect_pc = ae_tgt[t];
         cyc(1);
         redirect = 1'b0;
         cyc(2);
         #2;
         check_bit("ae_valid", instr_valid, 1'b1);
         check_bit("ae_adel", adel, 1'b1);
         check("ae_pc", instr_pc, ae_tgt[t]);
         check("ae_instr", instr, 32'h0);
         check_bit("ae_req", im_req, 1'b0);
         cyc(1);
         instr_ready = 1'b1;
         cyc(3);
         #2;
         check_bit("ae_req_err", im_req, 1'b0);
         check_bit("ae_empty", instr_valid, 1'b0);
      end
      cyc(1);
      redirect = 1'b1; redirect_pc = 32'h3000;
      cyc(1);
      redirect = 1'b0;
      #2;
      check_bit("ae_resume_req", im_req, 1'b1);
      cyc(6);

      // Walk off the top of the legal range.
      redirect = 1'b1; redirect_pc = 32'h6FF8;
      cyc(1);
      redirect = 1'b0; pop_log.delete();
      cyc(10);
      #2;
      check_bit("bnd_req", im_req, 1'b0);
      check_log("bnd_0", 0, 32'h6FF8);
      check_log("bnd_1", 1, 32'h6FFC);
      check_log("bnd_2", 2, 32'h7000);

      // Reset while the buffer is full and redirect is high.
      cyc(1);
      instr_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h3000;
      cyc(1);
      redirect = 1'b0;
      cyc(5);
      #2;
      check_bit("ri_full_req", im_req, 1'b0);
      cyc(1);
      reset = 1'b1; redirect = 1'b1; redirect_pc = 32'h3400;
      #2;
      check_bit("ri_im_req", im_req, 1'b0);
      check_bit("ri_valid", instr_valid, 1'b0);
      check("ri_instr", instr, 32'h0);
      check("ri_instr_pc", instr_pc, 32'h0);
      check_bit("ri_adel", adel, 1'b0);
      cyc(1);
      #2;
      check("ri_pc_in_reset", im_addr, RESET_PC);
      cyc(1);
      reset = 1'b0; redirect = 1'b0;
      #2;
      check("ri_first_addr", im_addr, 32'h3000);
      instr_ready = 1'b1;
      cyc(8);

      // Randomized traffic.
      gnt_pct = 60; rv_pct = 60; since = 0;
      for (int c = 0; c < 2000; c++) begin
         cyc(1);
         reset = 1'b0; exc = 1'b0; redirect = 1'b0;
         instr_ready = ($urandom_range(99) < 32'd70);
         r = int'($urandom_range(999));
         since++;
         if (r < 5) begin
            reset = 1'b1; since = 0;
         end else if (r < 15) begin
            exc = 1'b1; redirect = r[0]; redirect_pc = pick_target(int'($urandom_range(9)));
            since = 0;
         end else if (r < 60 || since >= 40) begin
            redirect = 1'b1; redirect_pc = pick_target(int'($urandom_range(9)));
            since = 0;
         end
      end
      cyc(1);
      reset = 1'b0; exc = 1'b0; redirect = 1'b0; instr_ready = 1'b1;
      gnt_pct = 100; rv_pct = 100;
      cyc(10);
      check_bit("progress", n_pop > 200, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
